data_mem_responder: RTL

Responder for the CPU data-memory port. Owns a word-addressed data RAM and a posted-write buffer. CPU stores are accepted in one cycle and drained to the RAM one per cycle under drain_en. CPU loads complete combinationally in the same cycle, with forwarding from pending buffered writes. It sits directly opposite the CPU's data_addr/mem_read_en/mem_write_en/mem_write_data/mem_read_data port.

---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/data_mem_responder_if.sv | 31 +++
 rtl/posted_write_buffer.sv | 70 +++++++
 rtl/data_mem_responder.sv | 114 +++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// data_mem_pkg : shared word width, posted-write entry type, error-bit indices
// Revision     : 1.0
// ============================================================================
package data_mem_pkg;

    localparam int WORD_W    = 32;
    // Widest word index a 32-bit byte address can carry; entries hold the
    // zero-extended index so the buffer does not depend on ADDR_W.
    localparam int IDX_MAX_W = 30;

    typedef logic [IDX_MAX_W-1:0] word_idx_t;

    typedef struct packed {
        word_idx_t         idx;
        logic [WORD_W-1:0] data;
    } buf_entry_t;

    localparam int ERR_ALIGN    = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_OVERFLOW = 2;
    localparam int ERR_W        = 3;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// data_mem_responder_if : CPU data-memory port (load/store bus)
// Revision              : 1.0
// ============================================================================
interface data_mem_responder_if;

    logic [31:0] data_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output data_addr,
        output mem_read_en,
        output mem_write_en,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  data_addr,
        input  mem_read_en,
        input  mem_write_en,
        input  mem_write_data,
        output mem_read_data
    );

endinterface
`default_nettype wire

// File: rtl/posted_write_buffer.sv
`default_nettype none
// ============================================================================
// posted_write_buffer : circular store FIFO with youngest-match forwarding
// Revision            : 1.0
// ============================================================================
module posted_write_buffer
    import data_mem_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  buf_entry_t        push_entry,
    input  logic              pop,
    input  word_idx_t         lookup_idx,
    output logic              hit,
    output logic [WORD_W-1:0] hit_data,
    output buf_entry_t        head_entry,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    buf_entry_t       r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_pos;

    // Caller only asserts push when not full (or popping) and pop when not empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + 1'b1;
            if (pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_entries[r_tail] <= push_entry;
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        w_pos    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_pos = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_entries[w_pos].idx == lookup_idx)) begin
                hit      = 1'b1;
                hit_data = r_entries[w_pos].data;
            end
        end
    end

    assign head_entry = r_entries[r_head];
    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : data RAM behind a posted-write buffer, same-cycle loads
// Revision           : 1.0
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter  int ADDR_W    = 10,
    parameter  int BUF_DEPTH = 4,
    localparam int CNT_W     = $clog2(BUF_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    data_mem_responder_if.slave        bus,
    input  logic                       drain_en,
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           buf_count,
    output logic                       buf_empty,
    output logic                       align_err,
    output logic                       range_err,
    output logic                       overflow_err
);

    logic [WORD_W-1:0] r_ram [1 << ADDR_W];
    logic [ERR_W-1:0]  r_err;

    logic              w_access;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_valid;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_store;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ERR_W-1:0]  w_err_event;
    logic              w_hit;
    logic [WORD_W-1:0] w_hit_data;
    buf_entry_t        w_head_entry;
    buf_entry_t        w_push_entry;
    logic              w_full;
    logic              w_empty;
    logic              unused_idx_hi;

    assign w_access       = bus.mem_read_en | bus.mem_write_en;
    assign w_misaligned   = |bus.data_addr[1:0];
    assign w_out_of_range = |bus.data_addr[31:ADDR_W+2];
    assign w_valid        = ~w_misaligned & ~w_out_of_range;
    assign w_word_idx     = bus.data_addr[ADDR_W+1:2];

    // A full buffer still takes a store when the head retires on the same edge.
    assign w_store = bus.mem_write_en & w_valid;
    assign w_pop   = drain_en & ~w_empty;
    assign w_push  = w_store & (~w_full | w_pop);
    assign w_drop  = w_store & ~w_push;

    assign w_push_entry.idx  = word_idx_t'(w_word_idx);
    assign w_push_entry.data = bus.mem_write_data;

    posted_write_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .lookup_idx (word_idx_t'(w_word_idx)),
        .hit        (w_hit),
        .hit_data   (w_hit_data),
        .head_entry (w_head_entry),
        .full       (w_full),
        .empty      (w_empty),
        .count      (buf_count)
    );

    always_ff @(posedge clk) begin
        if (w_pop) r_ram[w_head_entry.idx[ADDR_W-1:0]] <= w_head_entry.data;
    end

    // Upper index bits are always zero for entries that passed the range check.
    assign unused_idx_hi = |w_head_entry.idx[IDX_MAX_W-1:ADDR_W];

    always_comb begin
        w_err_event               = '0;
        w_err_event[ERR_ALIGN]    = w_access & w_misaligned;
        w_err_event[ERR_RANGE]    = w_access & w_out_of_range;
        w_err_event[ERR_OVERFLOW] = w_drop;
    end

    // Clear first, then OR in new events so a coincident event wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~{ERR_W{err_clr}}) | w_err_event;
        end
    end

    always_comb begin
        bus.mem_read_data = '0;
        if (bus.mem_read_en && w_valid) begin
            bus.mem_read_data = w_hit ? w_hit_data : r_ram[w_word_idx];
        end
    end

    assign buf_empty    = w_empty;
    assign align_err    = r_err[ERR_ALIGN];
    assign range_err    = r_err[ERR_RANGE];
    assign overflow_err = r_err[ERR_OVERFLOW];

endmodule
`default_nettype wire
